// File: rtl/vector_element_streamer.sv
// Streams a parallel 4-element vector out one element per transfer, lowest index first.
// Optional one-vector prefetch register (zero-bubble streaming) under `VECTOR_STREAMER_PREFETCH_EN.
module vector_element_streamer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    clear,
    input  logic [4*DATA_WIDTH-1:0] in_vector,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   element,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    new_vector,
    output logic [1:0]              vector_index,
    output logic                    last
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [3*DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   element_q, element_d;
    logic [1:0]              index_q, index_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept;

`ifdef VECTOR_STREAMER_PREFETCH_EN
    logic [4*DATA_WIDTH-1:0] prefetch_q, prefetch_d;
    logic                    prefetch_valid_q, prefetch_valid_d;

    assign in_ready = en && !clear && (state_q == IDLE || !prefetch_valid_q);
`else
    assign in_ready = en && !clear && (state_q == IDLE);
`endif

    assign accept       = in_valid && in_ready;
    assign new_vector   = en && !clear && out_valid_q && out_ready;
    assign last         = out_valid_q && (index_q == 2'd3);
    assign element      = element_q;
    assign out_valid    = out_valid_q;
    assign vector_index = index_q;

    // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        element_d   = element_q;
        index_d     = index_q;
        out_valid_d = out_valid_q;
`ifdef VECTOR_STREAMER_PREFETCH_EN
        prefetch_d       = prefetch_q;
        prefetch_valid_d = prefetch_valid_q;
`endif
        if (en) begin
            if (clear) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                index_d     = 2'd0;
`ifdef VECTOR_STREAMER_PREFETCH_EN
                prefetch_valid_d = 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            element_d   = in_vector[DATA_WIDTH-1:0];
                            shift_d     = in_vector[4*DATA_WIDTH-1:DATA_WIDTH];
                            index_d     = 2'd0;
                            out_valid_d = 1'b1;
                            state_d     = STREAM;
                        end
                    end
                    STREAM: begin
                        if (new_vector) begin
                            if (index_q != 2'd3) begin
                                element_d = shift_q[DATA_WIDTH-1:0];
                                shift_d   = {{DATA_WIDTH{1'b0}}, shift_q[3*DATA_WIDTH-1:DATA_WIDTH]};
                                index_d   = index_q + 2'd1;
                            end else begin
                                index_d = 2'd0;
`ifdef VECTOR_STREAMER_PREFETCH_EN
                                // Hand over the buffered vector (or one arriving right now) with no bubble.
                                if (prefetch_valid_q) begin
                                    element_d        = prefetch_q[DATA_WIDTH-1:0];
                                    shift_d          = prefetch_q[4*DATA_WIDTH-1:DATA_WIDTH];
                                    prefetch_valid_d = 1'b0;
                                end else if (accept) begin
                                    element_d = in_vector[DATA_WIDTH-1:0];
                                    shift_d   = in_vector[4*DATA_WIDTH-1:DATA_WIDTH];
                                end else begin
                                    state_d     = IDLE;
                                    out_valid_d = 1'b0;
                                end
`else
                                state_d     = IDLE;
                                out_valid_d = 1'b0;
`endif
                            end
                        end
`ifdef VECTOR_STREAMER_PREFETCH_EN
                        if (accept && !(new_vector && index_q == 2'd3)) begin
                            prefetch_d       = in_vector;
                            prefetch_valid_d = 1'b1;
                        end
`endif
                    end
                    default: begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            element_q   <= '0;
            index_q     <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            element_q   <= element_d;
            index_q     <= index_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef VECTOR_STREAMER_PREFETCH_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prefetch_q       <= '0;
            prefetch_valid_q <= 1'b0;
        end else begin
            prefetch_q       <= prefetch_d;
            prefetch_valid_q <= prefetch_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_vector_element_streamer.sv
// Scoreboard bench for vector_element_streamer: expected elements are queued on input accept
// and compared on each transfer; a reference vector_index_counter tracks vector_index.
module tb_vector_element_streamer;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b1;
    logic          clear = 1'b0;
    logic [4*DW-1:0] in_vector = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] element;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          new_vector;
    logic [1:0]    vector_index;
    logic          last;

    vector_element_streamer #(.DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .en           (en),
        .clear        (clear),
        .in_vector    (in_vector),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .element      (element),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .new_vector   (new_vector),
        .vector_index (vector_index),
        .last         (last)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] elem;
        logic [1:0]    idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   xfer_cyc[$];
    logic [1:0] ref_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Downstream vector_index_counter driven by the same strobe and clear.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)        ref_idx <= 2'd0;
        else if (clear)      ref_idx <= 2'd0;
        else if (new_vector) ref_idx <= ref_idx + 2'd1;
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check("index_vs_counter", 32'(vector_index), 32'(ref_idx));
            if (new_vector) begin
                xfer_cnt++;
                xfer_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_transfer", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("element", 32'(element), 32'(mon_e.elem));
                    check("vector_index", 32'(vector_index), 32'(mon_e.idx));
                    check("last", 32'(last), 32'(mon_e.idx == 2'd3));
                end
            end
        end
    end

    // Presents v until accepted; returns 1 after the accepting edge with in_valid still high.
    task automatic offer(input logic [4*DW-1:0] v);
        bit   done = 1'b0;
        exp_t e;
        in_vector = v;
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                for (int k = 0; k < 4; k++) begin
                    e.elem = v[k*DW +: DW];
                    e.idx  = 2'(k);
                    sb.push_back(e);
                end
                done = 1'b1;
            end
            @(posedge clock); #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_xfers(input int target);
        int guard = 0;
        while (xfer_cnt < target && guard < 60) begin
            @(posedge clock); #1;
            guard++;
        end
        if (xfer_cnt < target) check("xfer_timeout", 32'(xfer_cnt), 32'(target));
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int base2;

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_element", 32'(element), 32'd0);
        check("rst_index", 32'(vector_index), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_new_vector", 32'(new_vector), 32'd0);
        step();

        // Single vector
        out_ready = 1'b1;
        base = xfer_cnt;
        offer(32'h44332211);
        in_valid = 1'b0;
        wait_xfers(base + 4);
        check("single_span", 32'(xfer_cyc[base+3] - xfer_cyc[base]), 32'd3);
        @(negedge clock);
        check("single_idle_after", 32'(out_valid), 32'd0);
        step();

        // Backpressure at index 1
        out_ready = 1'b0;
        base = xfer_cnt;
        offer(32'h44332211);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("bp_element", 32'(element), 32'h22);
            check("bp_index", 32'(vector_index), 32'd1);
            check("bp_new_vector", 32'(new_vector), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        wait_xfers(base + 4);
        step();
        check("bp_total", 32'(xfer_cnt - base), 32'd4);

        // Back-to-back vectors with in_valid held
        base = xfer_cnt;
        offer(32'hD4C3B2A1);
        offer(32'h0F0E0D0C);
        in_valid = 1'b0;
        wait_xfers(base + 8);
`ifdef VECTOR_STREAMER_PREFETCH_EN
        check("b2b_span", 32'(xfer_cyc[base+7] - xfer_cyc[base]), 32'd7);
        check("b2b_gap", 32'(xfer_cyc[base+4] - xfer_cyc[base+3]), 32'd1);
`else
        check("b2b_span", 32'(xfer_cyc[base+7] - xfer_cyc[base]), 32'd8);
        check("b2b_gap", 32'(xfer_cyc[base+4] - xfer_cyc[base+3]), 32'd2);
`endif
        step();

        // Mid-vector clear at index 2
        offer(32'h88776655);
        in_valid = 1'b0;
        step();
        step();
        clear     = 1'b1;
        in_vector = 32'hDEADBEEF;
        in_valid  = 1'b1;
        sb.delete();
        @(negedge clock);
        check("clr_index_before", 32'(vector_index), 32'd2);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        check("clr_new_vector", 32'(new_vector), 32'd0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_index", 32'(vector_index), 32'd0);
        step();
        base = xfer_cnt;
        offer(32'h5A4B3C2D);
        in_valid = 1'b0;
        wait_xfers(base + 4);
        step();

        // Enable freeze at index 1
        base = xfer_cnt;
        offer(32'h13121110);
        in_valid = 1'b0;
        step();
        en = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("en_new_vector", 32'(new_vector), 32'd0);
            check("en_in_ready", 32'(in_ready), 32'd0);
            check("en_index", 32'(vector_index), 32'd1);
            step();
        end
        en = 1'b1;
        @(negedge clock);
        check("en_resume_index", 32'(vector_index), 32'd1);
        check("en_resume_element", 32'(element), 32'h11);
        wait_xfers(base + 4);
        step();

        // Async reset mid-stream at index 3
        offer(32'h99887766);
        in_valid = 1'b0;
        step();
        step();
        step();
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_element", 32'(element), 32'd0);
        check("areset_index", 32'(vector_index), 32'd0);
        check("areset_last", 32'(last), 32'd0);
        check("areset_new_vector", 32'(new_vector), 32'd0);
        check("areset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        base2 = xfer_cnt;
        step();
        check("areset_no_xfer", 32'(xfer_cnt - base2), 32'd0);
        check("areset_idle", 32'(out_valid), 32'd0);

        // Recovery after reset
        base = xfer_cnt;
        offer(32'hA3A2A1A0);
        in_valid = 1'b0;
        wait_xfers(base + 4);
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
